// File: rtl/vram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vram_responder_pkg
//  Purpose  : Shared types and default widths for the video SRAM responder.
//  Revision : 1.0  initial release
// ============================================================================
package vram_responder_pkg;

    localparam int unsigned c_DEF_ADDR_W     = 17;
    localparam int unsigned c_DEF_DATA_W     = 8;
    localparam int unsigned c_DEF_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_RD_ADDR  = 3'd4,
        ST_RD_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vram_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : vram_responder_if
//  Purpose  : Initiator-to-responder op_* bus (DMA / CPU side of video SRAM).
//  Revision : 1.0  initial release
// ============================================================================
interface vram_responder_if
    import vram_responder_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int DATA_W = c_DEF_DATA_W
);
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              op_re;
    logic              op_we;
    logic              op_wait;
    logic [DATA_W-1:0] op_rdata;
    logic              op_rvalid;

    modport master (
        output op_addr, op_wdata, op_re, op_we,
        input  op_wait, op_rdata, op_rvalid
    );

    modport slave (
        input  op_addr, op_wdata, op_re, op_we,
        output op_wait, op_rdata, op_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/vram_responder_wfifo.sv
`default_nettype none
// ============================================================================
//  Module   : vram_wfifo
//  Purpose  : Posted-write FIFO; pointers carry a wrap bit so full/empty come
//             straight from a pointer compare. Push and pop may coincide.
//  Revision : 1.0  initial release
// ============================================================================
module vram_wfifo
    import vram_responder_pkg::*;
#(
    parameter int WIDTH = c_DEF_ADDR_W + c_DEF_DATA_W,
    parameter int DEPTH = c_DEF_FIFO_DEPTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         wdata,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   level
);
    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign level     = r_wr_ptr - r_rd_ptr;
    assign rdata     = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointer update; reset discards any queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
    end
endmodule
`default_nettype wire

// File: rtl/vram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : vram_responder
//  Purpose  : Shares one async video SRAM between VGA scan-out (active video)
//             and op_* bus traffic (blanking). Writes are posted into a FIFO
//             and drained in blanking; reads wait until the FIFO is empty.
//  Revision : 1.0  initial release
// ============================================================================
module vram_responder
    import vram_responder_pkg::*;
#(
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    vram_responder_if.slave        bus,
    input  wire logic              vga_blank,
    input  wire logic [ADDR_W-1:0] pix_addr,
    output logic      [DATA_W-1:0] pix_data,
    output logic                   pix_valid,
    output logic      [ADDR_W-1:0] sram_addr,
    output logic      [DATA_W-1:0] sram_dq_o,
    output logic                   sram_dq_oe,
    input  wire logic [DATA_W-1:0] sram_dq_i,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t               r_state;
    logic                 r_rd_pend;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_rvalid;
    logic [DATA_W-1:0]    r_pix_data;
    logic                 r_pix_valid;

    logic                 w_full;
    logic                 w_empty;
    logic [c_LVL_W-1:0]   w_level;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [DATA_W-1:0]    w_head_data;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_acc;

    // A pending read blocks writes so the read can never be overtaken.
    assign w_push   = bus.op_we && !w_full && !r_rd_pend;
    // A held op_re in the op_rvalid cycle is the completing request, not a new one.
    assign w_rd_acc = bus.op_re && !bus.op_we && !r_rd_pend && !r_rvalid;
    assign w_pop    = (r_state == ST_WR_PULSE);

    assign w_head_addr = w_head[DATA_W +: ADDR_W];
    assign w_head_data = w_head[DATA_W-1:0];

    vram_wfifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata ({bus.op_addr, bus.op_wdata}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Arbitration FSM plus registered read/pixel results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SCAN;
            r_rd_pend   <= 1'b0;
            r_rd_addr   <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_rvalid    <= 1'b0;
            r_pix_valid <= 1'b0;
            if (w_rd_acc) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= bus.op_addr;
            end
            case (r_state)
                ST_SCAN: begin
                    r_pix_data  <= sram_dq_i;
                    r_pix_valid <= 1'b1;
                    if (vga_blank) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!vga_blank)     r_state <= ST_SCAN;
                    else if (!w_empty)  r_state <= ST_WR_SETUP;
                    else if (r_rd_pend) r_state <= ST_RD_ADDR;
                end
                ST_WR_SETUP: r_state <= ST_WR_PULSE;
                ST_WR_PULSE: begin
                    // Chain straight into the next entry for a 2-cycle drain rate.
                    if (!vga_blank)                       r_state <= ST_SCAN;
                    else if (w_level > c_LVL_W'(1))       r_state <= ST_WR_SETUP;
                    else                                  r_state <= ST_IDLE;
                end
                ST_RD_ADDR: r_state <= vga_blank ? ST_RD_DONE : ST_SCAN;
                ST_RD_DONE: begin
                    // Abort keeps the request pending for the next blank.
                    if (vga_blank) begin
                        r_rdata   <= sram_dq_i;
                        r_rvalid  <= 1'b1;
                        r_rd_pend <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state   <= ST_SCAN;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

    // SRAM pin decode; pins sit idle while reset is asserted.
    always_comb begin
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        if (rst_n) begin
            case (r_state)
                ST_SCAN: begin
                    sram_addr = pix_addr;
                    sram_oe_n = 1'b0;
                end
                ST_WR_SETUP: begin
                    sram_addr  = w_head_addr;
                    sram_dq_o  = w_head_data;
                    sram_dq_oe = 1'b1;
                end
                ST_WR_PULSE: begin
                    sram_addr  = w_head_addr;
                    sram_dq_o  = w_head_data;
                    sram_dq_oe = 1'b1;
                    sram_we_n  = 1'b0;
                end
                ST_RD_ADDR, ST_RD_DONE: begin
                    sram_addr = r_rd_addr;
                    sram_oe_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.op_wait   = rst_n && (r_rd_pend || (bus.op_we && w_full) ||
                                     (bus.op_re && !bus.op_we && !r_rvalid));
    assign bus.op_rdata  = r_rdata;
    assign bus.op_rvalid = r_rvalid;
    assign pix_data      = r_pix_data;
    assign pix_valid     = r_pix_valid;
endmodule
`default_nettype wire

// File: tb/tb_vram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_responder
//  Purpose  : Directed self-checking bench for vram_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vram_responder;
    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_blank;
    logic [AW-1:0] pix_addr;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o;
    logic [DW-1:0] sram_dq_i;
    logic          sram_dq_oe;
    logic          sram_oe_n;
    logic          sram_we_n;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bit [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] log_a [$];
    logic [DW-1:0] log_d [$];
    int            log_c [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vram_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_responder #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .vga_blank  (vga_blank),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    // Async SRAM model: read when output-enabled, write captured mid-pulse.
    assign sram_dq_i = (!sram_oe_n) ? mem[sram_addr] : 8'h00;

    always @(negedge clk) begin
        if (rst_n && !sram_we_n) begin
            mem[sram_addr] = sram_dq_o;
            log_a.push_back(sram_addr);
            log_d.push_back(sram_dq_o);
            log_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  allw;
        bit  anyv;
        int  ls;

        mem[17'h00100] = 8'h5A;
        mem[17'h00010] = 8'hC3;
        mem[17'h00050] = 8'h7E;
        rst_n = 1'b0;
        vga_blank = 1'b0;
        pix_addr = 17'h00100;
        bus.op_addr = '0; bus.op_wdata = '0; bus.op_re = 1'b0; bus.op_we = 1'b0;

        // ---- reset values
        tick; tick; tick;
        chk("rst_sram", {sram_we_n, sram_oe_n, sram_dq_oe, 15'd0, sram_addr}, {3'b110, 15'd0, 17'd0});
        chk("rst_bus", {bus.op_wait, bus.op_rvalid, bus.op_rdata}, 32'd0);
        chk("rst_pix", {pix_valid, pix_data}, 32'd0);

        // ---- scan-out
        rst_n = 1'b1;
        tick;
        chk("scan_pix", {pix_valid, pix_data}, {1'b1, 8'h5A});
        chk("scan_pins", {sram_we_n, sram_oe_n, 15'd0, sram_addr}, {2'b10, 15'd0, 17'h00100});

        // ---- 4 posted writes during active video, 5th blocked
        for (int i = 0; i < 4; i++) begin
            bus.op_we = 1'b1; bus.op_addr = 17'h1F000 + AW'(i); bus.op_wdata = 8'h10 + 8'(i);
            #1;
            chk("wr_accept", bus.op_wait, 1'b0);
            tick;
        end
        bus.op_addr = 17'h1F004; bus.op_wdata = 8'h14;
        #1;
        chk("wr_full_wait", bus.op_wait, 1'b1);
        bus.op_we = 1'b0;
        tick;
        chk("no_wr_active", log_a.size(), 0);

        vga_blank = 1'b1;
        for (int i = 0; i < 14; i++) tick;
        chk("drain_cnt", log_a.size(), 4);
        if (log_a.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("drain_addr", log_a[i], 17'h1F000 + AW'(i));
                chk("drain_data", log_d[i], 8'h10 + 8'(i));
            end
            for (int i = 1; i < 4; i++) chk("drain_rate", log_c[i] - log_c[i-1], 2);
        end

        // ---- read in blank with empty FIFO
        bus.op_re = 1'b1; bus.op_addr = 17'h00010;
        #1;
        chk("rd_wait_req", bus.op_wait, 1'b1);
        tick;
        n = 0; allw = 1'b1;
        while (!bus.op_rvalid && n < 10) begin
            allw &= bus.op_wait;
            tick;
            n++;
        end
        chk("rd_latency", n, 3);
        chk("rd_wait_hold", allw, 1'b1);
        chk("rd_data", bus.op_rdata, 8'hC3);
        chk("rd_wait_done", bus.op_wait, 1'b0);
        bus.op_re = 1'b0;
        tick;
        chk("rd_pulse_1cyc", bus.op_rvalid, 1'b0);

        // ---- read-after-write
        bus.op_we = 1'b1; bus.op_addr = 17'h00020; bus.op_wdata = 8'hAA;
        tick;
        bus.op_we = 1'b0; bus.op_re = 1'b1;
        tick;
        n = 0;
        while (!bus.op_rvalid && n < 20) begin tick; n++; end
        chk("raw_done", bus.op_rvalid, 1'b1);
        chk("raw_data", bus.op_rdata, 8'hAA);
        bus.op_re = 1'b0;
        tick;

        // ---- blank falls during WR_PULSE
        bus.op_we = 1'b1; bus.op_addr = 17'h00040; bus.op_wdata = 8'h33;
        tick;
        bus.op_we = 1'b0;
        n = 0;
        while (sram_we_n && n < 10) begin tick; n++; end
        chk("wp_seen", sram_we_n, 1'b0);
        vga_blank = 1'b0; pix_addr = 17'h00010;
        tick;
        chk("wp_complete", {log_a[log_a.size()-1], 7'd0, log_d[log_d.size()-1]}, {17'h00040, 7'd0, 8'h33});
        chk("wp_pv_low", {pix_valid, pix_data}, {1'b0, 8'h5A});
        tick;
        chk("wp_pv_back", {pix_valid, pix_data}, {1'b1, 8'hC3});

        // ---- blank falls during RD_ADDR
        bus.op_re = 1'b1; bus.op_addr = 17'h00050;
        tick;
        allw = 1'b1; anyv = 1'b0;
        for (int i = 0; i < 3; i++) begin allw &= bus.op_wait; anyv |= bus.op_rvalid; tick; end
        chk("rd_active_held", {allw, anyv}, 2'b10);
        vga_blank = 1'b1;
        n = 0;
        while (!(!sram_oe_n && sram_addr == 17'h00050) && n < 10) begin tick; n++; end
        chk("ra_seen", {sram_oe_n, 15'd0, sram_addr}, {1'b0, 15'd0, 17'h00050});
        vga_blank = 1'b0;
        allw = 1'b1; anyv = 1'b0;
        for (int i = 0; i < 3; i++) begin tick; allw &= bus.op_wait; anyv |= bus.op_rvalid; end
        chk("ra_abort", {allw, anyv}, 2'b10);
        vga_blank = 1'b1;
        n = 0;
        while (!bus.op_rvalid && n < 20) begin tick; n++; end
        chk("ra_reissue", bus.op_rvalid, 1'b1);
        chk("ra_data", bus.op_rdata, 8'h7E);
        bus.op_re = 1'b0;
        tick;

        // ---- simultaneous read and write: write wins
        bus.op_re = 1'b1; bus.op_we = 1'b1; bus.op_addr = 17'h00060; bus.op_wdata = 8'h99;
        #1;
        chk("rw_wait", bus.op_wait, 1'b0);
        tick;
        bus.op_re = 1'b0; bus.op_we = 1'b0;
        anyv = 1'b0;
        for (int i = 0; i < 10; i++) begin tick; anyv |= bus.op_rvalid; end
        chk("rw_no_rvalid", anyv, 1'b0);
        chk("rw_written", {log_a[log_a.size()-1], 7'd0, log_d[log_d.size()-1]}, {17'h00060, 7'd0, 8'h99});
        chk("rw_no_pend", bus.op_wait, 1'b0);

        // ---- reset with queued writes
        vga_blank = 1'b0;
        tick; tick;
        for (int i = 0; i < 2; i++) begin
            bus.op_we = 1'b1; bus.op_addr = 17'h00070 + AW'(i); bus.op_wdata = 8'hE0 + 8'(i);
            tick;
        end
        bus.op_we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_sram", {sram_we_n, sram_oe_n, sram_dq_oe, 15'd0, sram_addr}, {3'b110, 15'd0, 17'd0});
        chk("mrst_bus", {bus.op_wait, bus.op_rvalid, bus.op_rdata}, 32'd0);
        chk("mrst_pix", {pix_valid, pix_data}, 32'd0);
        ls = log_a.size();
        tick; tick;
        vga_blank = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        chk("mrst_discard", log_a.size(), ls);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
